sot_align_sequencer: RTL and testbench

Sequences start-of-frame (SOT) alignment across all VFAT frame aligners on the OptoHybrid trigger path. Releases each aligner from reset one VFAT at a time, waits for that VFAT's aligned flag within a programmable timeout, and retries up to a limit. It then monitors aligned VFATs for SOT instability and re-aligns any VFAT that loses lock. Sits between the slow-control registers and the per-VFAT frame aligner array, driving each aligner's reset and mask inputs.

---
 rtl/sot_align_pkg.sv | 24 ++
 rtl/lowest_set_idx.sv | 23 ++
 rtl/sot_align_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_sot_align_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sot_align_pkg.sv
// Shared types for the SOT alignment sequencer: FSM states, defaults and the
// status word exposed to slow control.
package sot_align_pkg;

  localparam int unsigned NVFAT_DEF    = 24;
  localparam int unsigned RST_HOLD_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_ALL,
    ST_SELECT,
    ST_RELEASE,
    ST_WAIT,
    ST_RETRY,
    ST_MONITOR
  } state_e;

  typedef struct packed {
    logic [NVFAT_DEF-1:0] good;
    logic [NVFAT_DEF-1:0] failed;
    logic [7:0]           relock_cnt;
  } status_t;

endpackage

// File: rtl/lowest_set_idx.sv
// Priority encoder: index of the lowest set bit of vec_i, with a valid flag.
module lowest_set_idx #(
  parameter int unsigned N     = 24,
  parameter int unsigned IDX_W = 5
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sot_align_sequencer.sv
// Releases VFAT frame aligners one at a time, waits for SOT lock with timeout and
// retries, then watches locked VFATs and re-aligns any that lose lock.
module sot_align_sequencer
  import sot_align_pkg::*;
#(
  parameter int unsigned NVFAT     = NVFAT_DEF,
  parameter int unsigned RST_HOLD  = RST_HOLD_DEF,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 realign,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic [3:0]           max_retries,
  input  logic [NVFAT-1:0]     vfat_mask_i,
  input  logic [NVFAT-1:0]     sot_is_aligned,
  input  logic [NVFAT-1:0]     sot_unstable,
  output logic [NVFAT-1:0]     aligner_reset,
  output logic [NVFAT-1:0]     aligner_mask,
  output logic [NVFAT-1:0]     vfat_good,
  output logic [NVFAT-1:0]     vfat_failed,
  output logic [4:0]           cur_vfat,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           relock_cnt
);

  localparam int unsigned CUR_W  = 5;
  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
  localparam logic [CUR_W-1:0]  LAST_IDX  = CUR_W'(NVFAT - 1);

  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
  logic [3:0]             retries_q, retries_d;
  logic [CUR_W-1:0]       cur_q, cur_d, next_cur;
  logic [NVFAT-1:0]       good_q, good_d;
  logic [NVFAT-1:0]       failed_q, failed_d;
  logic [NVFAT-1:0]       arst_q, arst_d;
  logic [NVFAT-1:0]       mask_q;
  logic [7:0]             relock_q, relock_d;
  logic                   busy_q, done_q;

  logic [NVFAT-1:0]       ge_mask, cand, lost, enc_vec;
  logic [CUR_W-1:0]       enc_idx;
  logic                   enc_valid;
  logic                   start_seq;

  // Candidates for SELECT: unmasked, unresolved, at or above cur_vfat.
  always_comb begin
    ge_mask = '0;
    for (int unsigned i = 0; i < NVFAT; i++) begin
      ge_mask[i] = (CUR_W'(i) >= cur_q);
    end
  end

  assign cand    = ~vfat_mask_i & ~good_q & ~failed_q & ge_mask;
  assign lost    = good_q & (sot_unstable | ~sot_is_aligned);
  assign enc_vec = (state_q == ST_MONITOR) ? lost : cand;

  lowest_set_idx #(
    .N     (NVFAT),
    .IDX_W (CUR_W)
  ) u_enc (
    .vec_i   (enc_vec),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  assign next_cur  = (cur_q >= LAST_IDX) ? cur_q : cur_q + CUR_W'(1);
  assign start_seq = realign || (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    tmo_d     = tmo_q;
    retries_d = retries_q;
    cur_d     = cur_q;
    good_d    = good_q;
    failed_d  = failed_q;
    arst_d    = arst_q;
    relock_d  = relock_q;

    if (!enable) begin
      state_d   = ST_IDLE;
      arst_d    = '1;
      good_d    = '0;
      failed_d  = '0;
      cur_d     = '0;
      retries_d = '0;
    end else if (start_seq) begin
      state_d   = ST_RST_ALL;
      hold_d    = HOLD_LOAD;
      arst_d    = '1;
      good_d    = '0;
      failed_d  = '0;
      cur_d     = '0;
      retries_d = '0;
    end else begin
      case (state_q)
        ST_RST_ALL: begin
          if (hold_q == '0) state_d = ST_SELECT;
          else              hold_d  = hold_q - HOLD_W'(1);
        end
        ST_SELECT: begin
          if (enc_valid) begin
            cur_d           = enc_idx;
            arst_d[enc_idx] = 1'b0;
            state_d         = ST_RELEASE;
          end else begin
            state_d = ST_MONITOR;
          end
        end
        ST_RELEASE: begin
          tmo_d   = (timeout == '0) ? TIMEOUT_W'(1) : timeout;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          // Alignment takes priority over a same-cycle timeout expiry.
          if (sot_is_aligned[cur_q]) begin
            good_d[cur_q] = 1'b1;
            retries_d     = '0;
            cur_d         = next_cur;
            state_d       = ST_SELECT;
          end else if (tmo_q <= TIMEOUT_W'(1)) begin
            arst_d[cur_q] = 1'b1;
            if (retries_q < max_retries) begin
              retries_d = retries_q + 4'd1;
              hold_d    = HOLD_LOAD;
              state_d   = ST_RETRY;
            end else begin
              failed_d[cur_q] = 1'b1;
              retries_d       = '0;
              cur_d           = next_cur;
              state_d         = ST_SELECT;
            end
          end else begin
            tmo_d = tmo_q - TIMEOUT_W'(1);
          end
        end
        ST_RETRY: begin
          if (hold_q == '0) begin
            arst_d[cur_q] = 1'b0;
            state_d       = ST_RELEASE;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        ST_MONITOR: begin
          if (enc_valid) begin
            good_d[enc_idx] = 1'b0;
            arst_d[enc_idx] = 1'b1;
            if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
            cur_d     = enc_idx;
            retries_d = '0;
            hold_d    = HOLD_LOAD;
            state_d   = ST_RETRY;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Masked VFATs are never released and never report status.
    good_d   = good_d & ~vfat_mask_i;
    failed_d = failed_d & ~vfat_mask_i;
    arst_d   = arst_d | vfat_mask_i;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      tmo_q     <= '0;
      retries_q <= '0;
      cur_q     <= '0;
      good_q    <= '0;
      failed_q  <= '0;
      arst_q    <= '1;
      mask_q    <= '1;
      relock_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      tmo_q     <= tmo_d;
      retries_q <= retries_d;
      cur_q     <= cur_d;
      good_q    <= good_d;
      failed_q  <= failed_d;
      arst_q    <= arst_d;
      mask_q    <= ~good_d;
      relock_q  <= relock_d;
      busy_q    <= (state_d != ST_IDLE) && (state_d != ST_MONITOR);
      done_q    <= (state_d == ST_MONITOR);
    end
  end

  assign aligner_reset = arst_q;
  assign aligner_mask  = mask_q;
  assign vfat_good     = good_q;
  assign vfat_failed   = failed_q;
  assign cur_vfat      = cur_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign relock_cnt    = relock_q;

endmodule

// File: tb/tb_sot_align_sequencer.sv
// Directed bench for sot_align_sequencer with a simple per-VFAT aligner model.
module tb_sot_align_sequencer;

  localparam int unsigned NV = 24;

  logic          clock = 1'b0;
  logic          reset_n, enable, realign;
  logic [15:0]   timeout;
  logic [3:0]    max_retries;
  logic [NV-1:0] vfat_mask_i, sot_is_aligned, sot_unstable;
  logic [NV-1:0] aligner_reset, aligner_mask, vfat_good, vfat_failed;
  logic [4:0]    cur_vfat;
  logic          busy, done;
  logic [7:0]    relock_cnt;

  sot_align_sequencer #(.NVFAT(NV), .RST_HOLD(4), .TIMEOUT_W(16)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .realign        (realign),
    .timeout        (timeout),
    .max_retries    (max_retries),
    .vfat_mask_i    (vfat_mask_i),
    .sot_is_aligned (sot_is_aligned),
    .sot_unstable   (sot_unstable),
    .aligner_reset  (aligner_reset),
    .aligner_mask   (aligner_mask),
    .vfat_good      (vfat_good),
    .vfat_failed    (vfat_failed),
    .cur_vfat       (cur_vfat),
    .busy           (busy),
    .done           (done),
    .relock_cnt     (relock_cnt)
  );

  always #5 clock = ~clock;

  // Aligner model: locks align_dly cycles after its reset drops, unless never_align.
  int unsigned   align_dly;
  logic [NV-1:0] never_align;
  int unsigned   acnt [NV];
  logic [NV-1:0] prev_rst;
  int            falls_q[$];
  int            pulse_q[$];
  int            watch;
  int            hi_len;

  always @(negedge clock) begin
    for (int i = 0; i < NV; i++) begin
      if (aligner_reset[i]) acnt[i] = 0;
      else if (acnt[i] < 15) acnt[i] = acnt[i] + 1;
      sot_is_aligned[i] = !aligner_reset[i] && (acnt[i] >= align_dly) && !never_align[i];
      if (prev_rst[i] && !aligner_reset[i]) falls_q.push_back(i);
    end
    if (aligner_reset[watch]) hi_len = hi_len + 1;
    else begin
      if (prev_rst[watch]) pulse_q.push_back(hi_len);
      hi_len = 0;
    end
    prev_rst = aligner_reset;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_done(input int max_cyc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done && n < max_cyc);
    check("wait_done", 32'(done), 32'd1);
  endtask

  task automatic restart();
    enable = 1'b0;
    step();
    step();
    falls_q.delete();
    pulse_q.delete();
    enable = 1'b1;
  endtask

  task automatic wait_in_wait(input logic [4:0] idx);
    int n = 0;
    while (!(cur_vfat == idx && !aligner_reset[idx] && busy) && n < 1000) begin
      step();
      n++;
    end
    check("reach_vfat", 32'(cur_vfat), 32'(idx));
    step();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_arst"},   32'(aligner_reset), 32'hFFFFFF);
    check({tag, "_mask"},   32'(aligner_mask),  32'hFFFFFF);
    check({tag, "_good"},   32'(vfat_good),     32'h0);
    check({tag, "_failed"}, 32'(vfat_failed),   32'h0);
    check({tag, "_cur"},    32'(cur_vfat),      32'h0);
    check({tag, "_busy"},   32'(busy),          32'h0);
    check({tag, "_done"},   32'(done),          32'h0);
    check({tag, "_relock"}, 32'(relock_cnt),    32'h0);
  endtask

  task automatic check_falls(input string tag, input int exp_n);
    int bad = 0;
    for (int k = 1; k < falls_q.size(); k++) if (falls_q[k] < falls_q[k-1]) bad++;
    check({tag, "_order"}, 32'(bad), 32'd0);
    check({tag, "_falls"}, 32'(falls_q.size()), 32'(exp_n));
  endtask

  initial begin
    int p0, p1, p2;
    reset_n = 1'b0; enable = 1'b0; realign = 1'b0;
    timeout = 16'd100; max_retries = 4'd0;
    vfat_mask_i = '0; sot_unstable = '0; never_align = '0;
    align_dly = 3; watch = 5; hi_len = 0;
    repeat (3) step();
    check_reset_vals("por");
    reset_n = 1'b1;
    step();

    // All VFATs masked: straight through to MONITOR.
    vfat_mask_i = '1;
    enable = 1'b1;
    wait_done(50, cyc);
    check("allmask_latency", 32'(cyc), 32'd6);
    check("allmask_good", 32'(vfat_good), 32'h0);
    check("allmask_arst", 32'(aligner_reset), 32'hFFFFFF);
    check("allmask_busy", 32'(busy), 32'd0);

    // All 24 align three cycles after release.
    vfat_mask_i = '0;
    restart();
    wait_done(400, cyc);
    check("all24_latency", 32'(cyc), 32'd102);
    check("all24_good", 32'(vfat_good), 32'hFFFFFF);
    check("all24_mask", 32'(aligner_mask), 32'h0);
    check("all24_failed", 32'(vfat_failed), 32'h0);
    check("all24_arst", 32'(aligner_reset), 32'h0);
    check("all24_cur", 32'(cur_vfat), 32'd23);
    check_falls("all24", 24);

    // VFAT 5 never aligns: three attempts, then failed.
    never_align = 24'h000020; max_retries = 4'd2; timeout = 16'd10; watch = 5;
    restart();
    wait_done(400, cyc);
    check("fail5_latency", 32'(cyc), 32'd140);
    check("fail5_failed", 32'(vfat_failed), 32'h000020);
    check("fail5_good", 32'(vfat_good), 32'hFFFFDF);
    check("fail5_arst", 32'(aligner_reset), 32'h000020);
    check("fail5_mask", 32'(aligner_mask), 32'h000020);
    check_falls("fail5", 26);
    p1 = (pulse_q.size() > 1) ? pulse_q[1] : -1;
    p2 = (pulse_q.size() > 2) ? pulse_q[2] : -1;
    check("fail5_pulses", 32'(pulse_q.size()), 32'd3);
    check("fail5_retry_len1", 32'(p1), 32'd4);
    check("fail5_retry_len2", 32'(p2), 32'd4);

    // VFATs 4..7 masked.
    never_align = '0; max_retries = 4'd0; timeout = 16'd100;
    vfat_mask_i = 24'h0000F0;
    restart();
    wait_done(400, cyc);
    check("mask_good", 32'(vfat_good), 32'hFFFF0F);
    check("mask_arst", 32'(aligner_reset), 32'h0000F0);
    check("mask_failed", 32'(vfat_failed), 32'h0);
    check_falls("mask", 20);

    // Instability on VFAT 12 while monitoring.
    watch = 12;
    step();
    pulse_q.delete();
    sot_unstable[12] = 1'b1;
    step();
    sot_unstable = '0;
    check("relock_good", 32'(vfat_good), 32'hFFEF0F);
    check("relock_cnt", 32'(relock_cnt), 32'd1);
    check("relock_cur", 32'(cur_vfat), 32'd12);
    check("relock_done", 32'(done), 32'd0);
    check("relock_busy", 32'(busy), 32'd1);
    check("relock_arst", 32'(aligner_reset), 32'h0010F0);
    check("relock_amask", 32'(aligner_mask), 32'h0010F0);
    wait_done(100, cyc);
    check("relock_regood", 32'(vfat_good), 32'hFFFF0F);
    check("relock_cnt_after", 32'(relock_cnt), 32'd1);
    p0 = (pulse_q.size() > 0) ? pulse_q[0] : -1;
    check("relock_pulses", 32'(pulse_q.size()), 32'd1);
    check("relock_pulse_len", 32'(p0), 32'd4);

    // realign pulse while waiting on VFAT 9.
    vfat_mask_i = '0; never_align = 24'h000200;
    restart();
    wait_in_wait(5'd9);
    check("realign_pre_good", 32'(vfat_good), 32'h0001FF);
    realign = 1'b1;
    step();
    realign = 1'b0;
    check("realign_arst", 32'(aligner_reset), 32'hFFFFFF);
    check("realign_good", 32'(vfat_good), 32'h0);
    check("realign_failed", 32'(vfat_failed), 32'h0);
    check("realign_cur", 32'(cur_vfat), 32'd0);
    check("realign_busy", 32'(busy), 32'd1);
    check("realign_done", 32'(done), 32'd0);
    never_align = '0;
    wait_done(400, cyc);
    check("realign_final_good", 32'(vfat_good), 32'hFFFFFF);

    // Lock on the exact expiry cycle, no retries allowed.
    align_dly = 2; timeout = 16'd1; max_retries = 4'd0;
    restart();
    wait_done(400, cyc);
    check("tmo1_good", 32'(vfat_good), 32'hFFFFFF);
    check("tmo1_failed", 32'(vfat_failed), 32'h0);

    // Timeout of zero behaves as one.
    timeout = 16'd0;
    restart();
    wait_done(400, cyc);
    check("tmo0_good", 32'(vfat_good), 32'hFFFFFF);
    check("tmo0_failed", 32'(vfat_failed), 32'h0);

    // One-cycle reset_n mid-WAIT.
    align_dly = 3; timeout = 16'd100; never_align = 24'h000200;
    restart();
    wait_in_wait(5'd9);
    reset_n = 1'b0;
    step();
    check_reset_vals("rst_mid");
    reset_n = 1'b1;
    never_align = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
